// File: rtl/ram_responder.sv
// ============================================================================
// Module   : ram_responder
// Purpose  : Four-phase request/ACK responder with an internal 32-bit word RAM.
//            Optional macro RAM_RESPONDER_RANGE_CHECK_EN flags addr >= DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ctrl_in,
  output logic [31:0] ctrl_out,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int          c_aw    = $clog2(DEPTH);
  localparam logic [31:0] c_depth = 32'(DEPTH);
  localparam logic [3:0]  c_wait  = 4'(LATENCY - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_ack  = 2'd2;
  localparam logic [1:0] c_st_rel  = 2'd3;

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic            r_arm;
  logic            r_wr;
  logic            r_bad;
  logic [c_aw-1:0] r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_data_out;
  logic [31:0]     r_mem [DEPTH];

  logic            w_rd;
  logic            w_wr;
  logic            w_illegal;
  logic            w_legal;
  logic            w_cap;
  logic            w_range_err;
  logic            w_acc;
  logic            w_acc_wr;
  logic [c_aw-1:0] w_acc_idx;
  logic [31:0]     w_acc_data;
  logic            w_unused;

  assign w_rd      = ctrl_in[0];
  assign w_wr      = ctrl_in[1];
  assign w_illegal = w_rd & w_wr;
  assign w_legal   = w_rd ^ w_wr;
  // r_arm delays the first capture to the second edge after reset release
  assign w_cap     = (r_state == c_st_idle) && r_arm && (w_rd || w_wr);
  assign w_unused  = &{1'b0, ctrl_in[31:2], addr[31:c_aw]};

`ifdef RAM_RESPONDER_RANGE_CHECK_EN
  assign w_range_err = (addr >= c_depth);
`else
  assign w_range_err = 1'b0;
`endif

  // Memory access happens on the edge that enters ACK
  always_comb begin
    w_acc      = 1'b0;
    w_acc_wr   = r_wr;
    w_acc_idx  = r_idx;
    w_acc_data = r_wdata;
    if ((r_state == c_st_wait) && (r_cnt == 4'd1) && !r_bad) begin
      w_acc = 1'b1;
    end
    if ((LATENCY == 1) && w_cap && w_legal && !w_range_err) begin
      w_acc      = 1'b1;
      w_acc_wr   = w_wr;
      w_acc_idx  = addr[c_aw-1:0];
      w_acc_data = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_st_idle;
      r_cnt      <= 4'd0;
      r_arm      <= 1'b0;
      r_wr       <= 1'b0;
      r_bad      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_data_out <= 32'd0;
    end else begin
      r_arm <= 1'b1;
      case (r_state)
        c_st_idle: begin
          if (w_cap) begin
            r_wr    <= w_wr;
            r_idx   <= addr[c_aw-1:0];
            r_wdata <= data_in;
            r_bad   <= w_illegal | w_range_err;
            if (w_illegal || (LATENCY == 1)) begin
              r_state <= c_st_ack;
            end else begin
              r_state <= c_st_wait;
              r_cnt   <= c_wait;
            end
          end
        end
        c_st_wait: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= c_st_ack;
          end
        end
        c_st_ack: begin
          if (!w_rd && !w_wr) begin
            r_state <= c_st_rel;
          end
        end
        c_st_rel: begin
          r_state <= c_st_idle;
          r_bad   <= 1'b0;
        end
        default: r_state <= c_st_idle;
      endcase
      if (w_acc && !w_acc_wr) begin
        r_data_out <= r_mem[w_acc_idx];
      end
    end
  end

  // Array has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (w_acc && w_acc_wr) begin
      r_mem[w_acc_idx] <= w_acc_data;
    end
  end

  assign ctrl_out = {29'd0, r_bad & r_state[1], r_state != c_st_idle, r_state == c_st_ack};
  assign data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// ============================================================================
// Module   : tb_ram_responder
// Purpose  : Directed self-checking bench for ram_responder (LATENCY 2 and 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_responder;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl_in, addr, din, ctrl_out, dout;
  logic [31:0] ctrl_in4, addr4, din4, ctrl_out4, dout4;
  int          total;
  int          bad;

  ram_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .ctrl_out(ctrl_out),
    .addr(addr), .data_in(din), .data_out(dout)
  );

  ram_responder #(.DEPTH(256), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in4), .ctrl_out(ctrl_out4),
    .addr(addr4), .data_in(din4), .data_out(dout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request on the LATENCY=2 instance and count edges until ACK
  task automatic run(input logic [31:0] ctl, input logic [31:0] a,
                     input logic [31:0] d, output int edges);
    ctrl_in = ctl;
    addr    = a;
    din     = d;
    edges   = 0;
    do begin
      step();
      edges++;
    end while (!ctrl_out[0] && edges < 20);
  endtask

  task automatic drop();
    ctrl_in = 32'd0;
    step();
    step();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    step();
    step();
    total++;
    if (ctrl_out !== 32'd0) begin bad++; $display("FAIL reset_ctrl got=%h want=00000000", ctrl_out); end
    total++;
    if (dout !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=00000000", dout); end
    total++;
    if (ctrl_out4 !== 32'd0) begin bad++; $display("FAIL reset_ctrl4 got=%h want=00000000", ctrl_out4); end
    // request already high when reset releases: must not be taken on first edge
    ctrl_in = 32'd2;
    addr    = 32'd0;
    din     = 32'h1111_1111;
    rst     = 1'b1;
    step();
    total++;
    if (ctrl_out !== 32'd0) begin bad++; $display("FAIL first_edge_capture got=%h want=00000000", ctrl_out); end
    n = 1;
    while (!ctrl_out[0] && n < 20) begin step(); n++; end
    total++;
    if (!ctrl_out[0]) begin bad++; $display("FAIL post_reset_ack got=0 want=1"); end
    drop();
  endtask

  task automatic test_write();
    ctrl_in = 32'd2;
    addr    = 32'd5;
    din     = 32'hDEAD_BEEF;
    step();
    total++;
    if (ctrl_out !== 32'h2) begin bad++; $display("FAIL wr_wait got=%h want=00000002", ctrl_out); end
    step();
    total++;
    if (ctrl_out !== 32'h3) begin bad++; $display("FAIL wr_ack got=%h want=00000003", ctrl_out); end
    step();
    total++;
    if (ctrl_out !== 32'h3) begin bad++; $display("FAIL wr_ack_hold got=%h want=00000003", ctrl_out); end
    ctrl_in = 32'd0;
    step();
    total++;
    if (ctrl_out !== 32'h2) begin bad++; $display("FAIL wr_release got=%h want=00000002", ctrl_out); end
    step();
    total++;
    if (ctrl_out !== 32'h0) begin bad++; $display("FAIL wr_idle got=%h want=00000000", ctrl_out); end
  endtask

  task automatic test_read();
    int n;
    run(32'd1, 32'd5, 32'd0, n);
    total++;
    if (n !== 2) begin bad++; $display("FAIL rd_latency got=%0d want=2", n); end
    total++;
    if (ctrl_out !== 32'h3) begin bad++; $display("FAIL rd_ctrl got=%h want=00000003", ctrl_out); end
    total++;
    if (dout !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", dout); end
    drop();
  endtask

  task automatic test_illegal();
    int n;
    run(32'd2, 32'd7, 32'h7777_7777, n);
    drop();
    ctrl_in = 32'd3;
    addr    = 32'd7;
    din     = 32'h0;
    step();
    total++;
    if (ctrl_out !== 32'h7) begin bad++; $display("FAIL ill_ack got=%h want=00000007", ctrl_out); end
    ctrl_in = 32'd0;
    step();
    total++;
    if (ctrl_out !== 32'h6) begin bad++; $display("FAIL ill_release got=%h want=00000006", ctrl_out); end
    step();
    total++;
    if (ctrl_out !== 32'h0) begin bad++; $display("FAIL ill_idle got=%h want=00000000", ctrl_out); end
    run(32'd1, 32'd7, 32'd0, n);
    total++;
    if (dout !== 32'h7777_7777) begin bad++; $display("FAIL ill_readback got=%h want=77777777", dout); end
    drop();
  endtask

  task automatic test_range();
    int n;
    run(32'd2, 32'd44, 32'hCAFE_F00D, n);
    drop();
    run(32'd2, 32'd300, 32'h1234_5678, n);
`ifdef RAM_RESPONDER_RANGE_CHECK_EN
    total++;
    if (ctrl_out !== 32'h7) begin bad++; $display("FAIL range_ctrl got=%h want=00000007", ctrl_out); end
`else
    total++;
    if (ctrl_out !== 32'h3) begin bad++; $display("FAIL range_ctrl got=%h want=00000003", ctrl_out); end
`endif
    drop();
    run(32'd1, 32'd44, 32'd0, n);
`ifdef RAM_RESPONDER_RANGE_CHECK_EN
    total++;
    if (dout !== 32'hCAFE_F00D) begin bad++; $display("FAIL range_read got=%h want=cafef00d", dout); end
`else
    total++;
    if (dout !== 32'h1234_5678) begin bad++; $display("FAIL range_read got=%h want=12345678", dout); end
`endif
    drop();
  endtask

  task automatic test_reset_abort();
    int n;
    run(32'd2, 32'd9, 32'h0BAD_F00D, n);
    drop();
    ctrl_in = 32'd2;
    addr    = 32'd9;
    din     = 32'hA5A5_A5A5;
    step();
    total++;
    if (ctrl_out !== 32'h2) begin bad++; $display("FAIL abort_wait got=%h want=00000002", ctrl_out); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (ctrl_out !== 32'h0) begin bad++; $display("FAIL abort_async got=%h want=00000000", ctrl_out); end
    ctrl_in = 32'd0;
    step();
    rst = 1'b1;
    step();
    step();
    total++;
    if (dout !== 32'd0) begin bad++; $display("FAIL abort_dout_cleared got=%h want=00000000", dout); end
    run(32'd1, 32'd9, 32'd0, n);
    total++;
    if (dout !== 32'h0BAD_F00D) begin bad++; $display("FAIL abort_readback got=%h want=0badf00d", dout); end
    drop();
  endtask

  task automatic test_back_to_back();
    int n;
    run(32'd2, 32'd10, 32'h0000_0001, n);
    total++;
    if (dout !== 32'h0BAD_F00D) begin bad++; $display("FAIL hold_on_write got=%h want=0badf00d", dout); end
    drop();
    run(32'd1, 32'd10, 32'd0, n);
    total++;
    if (dout !== 32'h0000_0001) begin bad++; $display("FAIL raw_b2b got=%h want=00000001", dout); end
    drop();
  endtask

  task automatic test_drop_wait();
    int n;
    ctrl_in4 = 32'd2;
    addr4    = 32'd3;
    din4     = 32'h3C3C_3C3C;
    n = 0;
    do begin step(); n++; end while (!ctrl_out4[0] && n < 20);
    total++;
    if (n !== 4) begin bad++; $display("FAIL l4_latency got=%0d want=4", n); end
    ctrl_in4 = 32'd0;
    step();
    step();
    ctrl_in4 = 32'd1;
    addr4    = 32'd3;
    step();
    total++;
    if (ctrl_out4 !== 32'h2) begin bad++; $display("FAIL l4_capture got=%h want=00000002", ctrl_out4); end
    ctrl_in4 = 32'd0;
    addr4    = 32'd77;
    step();
    step();
    total++;
    if (ctrl_out4 !== 32'h2) begin bad++; $display("FAIL l4_edge3 got=%h want=00000002", ctrl_out4); end
    step();
    total++;
    if (ctrl_out4 !== 32'h3) begin bad++; $display("FAIL l4_edge4_ack got=%h want=00000003", ctrl_out4); end
    total++;
    if (dout4 !== 32'h3C3C_3C3C) begin bad++; $display("FAIL l4_data got=%h want=3c3c3c3c", dout4); end
    step();
    total++;
    if (ctrl_out4 !== 32'h2) begin bad++; $display("FAIL l4_pulse_end got=%h want=00000002", ctrl_out4); end
    step();
    total++;
    if (ctrl_out4 !== 32'h0) begin bad++; $display("FAIL l4_idle got=%h want=00000000", ctrl_out4); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    ctrl_in  = 32'd0;
    addr     = 32'd0;
    din      = 32'd0;
    ctrl_in4 = 32'd0;
    addr4    = 32'd0;
    din4     = 32'd0;
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_range();
    test_reset_abort();
    test_back_to_back();
    test_drop_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in the internal array; power of two, 2..65536.
REQ-002 Parameter LATENCY, default 2: rising clk edges from request capture to ACK assertion; range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; low forces reset state immediately, release is sampled on clk.
REQ-005 ctrl_in  input  32  request pins from initiator: bit0 READ, bit1 WRITE; bits 31..2 ignored.
REQ-006 ctrl_out  output  32  status pins to initiator: bit0 ACK, bit1 BUSY, bit2 ERR; bits 31..3 driven 0.
REQ-007 addr  input  32  word address; must be stable while a request is high.
REQ-008 data_in  input  32  write data from initiator; must be stable while WRITE is high.
REQ-009 data_out  output  32  read data to initiator; valid while ACK is high after a READ.

Function
REQ-010 The handshake SHALL be four-phase: request high -> ACK high -> request low -> ACK low.
REQ-011 The FSM SHALL have states IDLE, WAIT, ACK and RELEASE, with BUSY = (state != IDLE).
REQ-012 In IDLE, a rising edge with exactly one of READ/WRITE high SHALL latch op, addr and data_in, and enter WAIT; if LATENCY = 1, it SHALL enter ACK directly.
REQ-013 WAIT SHALL count LATENCY-1 edges with a 4-bit down-counter, then enter ACK, so ACK is first high LATENCY edges after capture.
REQ-014 On the edge entering ACK, a WRITE SHALL commit the latched data to mem[index]; a READ SHALL load data_out with mem[index].
REQ-015 ACK SHALL hold high in state ACK until READ and WRITE are both sampled low; the FSM SHALL then enter RELEASE with ACK low.
REQ-016 RELEASE SHALL last one cycle and return to IDLE, giving a minimum of one idle cycle between transactions.
REQ-017 READ and WRITE both high in IDLE SHALL be an illegal request: no memory access, ERR=1, and the FSM enters ACK in one edge.
REQ-018 A request dropped during WAIT SHALL still complete; ACK SHALL pulse for one cycle, then the FSM enters RELEASE.
REQ-019 Changes to ctrl_in, addr or data_in after capture SHALL NOT affect the transaction in flight.
REQ-020 data_out SHALL hold its last read value until the next successful READ; a WRITE SHALL NOT change it.
REQ-021 ERR SHALL be set on entry to ACK for an errored transaction and cleared on entry to IDLE.
REQ-022 A read of a word written earlier SHALL return the written value (read-after-write on back-to-back transactions).

Reset
REQ-023 With rst low: state=IDLE, counter=0, ctrl_out=0, data_out=0, latched op/addr/data=0.
REQ-024 Reset mid-transaction SHALL abort it; a WRITE not yet in ACK SHALL NOT modify memory.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 After rst rises, the first request SHALL be captured no earlier than the second rising edge.

Configuration
REQ-027 Macro RAM_RESPONDER_RANGE_CHECK_EN controls address range checking.
- Defined: a captured addr >= DEPTH SHALL complete the handshake with ERR=1, no memory write, and data_out unchanged.
- Undefined: index = addr mod DEPTH (low log2(DEPTH) bits); ERR is asserted only for REQ-017.

Verification
REQ-028 Reset, then WRITE addr=5 data=0xDEADBEEF -> ACK high 2 edges after capture, ERR=0; drop WRITE -> ACK low, RELEASE one cycle, BUSY low.
REQ-029 READ addr=5 right after REQ-028 -> data_out=0xDEADBEEF while ACK is high, with ctrl_out = 0x00000003 (ACK and BUSY).
REQ-030 READ and WRITE both high, addr=7 -> ACK and ERR high after 1 edge; mem[7] unchanged on readback.
REQ-031 WRITE addr=300 data=0x12345678 with DEPTH=256:
- Macro defined: ERR=1 and mem[44] unchanged.
- Macro undefined: ERR=0 and a READ of addr=44 returns 0x12345678.
REQ-032 WRITE addr=9 data=0xA5A5A5A5 with rst pulsed low during WAIT -> ctrl_out=0 immediately; a later READ of addr=9 returns the prior contents.
REQ-033 READ with the request dropped after 1 cycle, LATENCY=4 -> ACK pulses exactly one cycle at edge 4 with valid data_out, then IDLE after RELEASE.
